seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Single-cycle ops complete with a registered result. Signed multiply (shift-add) and signed divide (restoring) run iteratively, one bit per cycle, instead of as large combinational arrays.
- Start/busy/done handshake toward the control unit. Results drive the HI/LO/Z register inputs.

Parameters:
- WIDTH, 32, operand width; must be a power of two ≥ 8.
- SHW, $clog2(WIDTH), shift-amount field width (derived; do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge
- clear  in  1  synchronous active-low reset
- start  in  1  request; accepted only when busy=0
- opcode  in  5  operation select, sampled on accept
- branch_flag  in  1  branch condition for op 10010, sampled on accept
- a  in  WIDTH  operand A (PC / unary source)
- y  in  WIDTH  operand Y (first binary source)
- b  in  WIDTH  operand B (second source / shift amount)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- result_hi  out  WIDTH  upper result (mul high word / div remainder)
- result_lo  out  WIDTH  lower result
- zero  out  1  {result_hi,result_lo}==0, registered with the result
- div_by_zero  out  1  last accepted op was div with b==0
- illegal_op  out  1  last accepted opcode was unsupported

Behaviour:
- Reset (clear=0 at an edge): state=IDLE; all outputs 0. Takes priority over everything, including mid-iteration.
- States and transitions:
  - IDLE: start=1 latches operands, opcode and branch_flag; go to DONE for single-cycle ops, MUL for 01110, DIV for 01111.
  - MUL / DIV: busy=1; iteration counter runs WIDTH cycles, then go to FIX.
  - FIX: busy=1; sign correction; go to DONE.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- start while busy=1 is ignored; the in-flight op is unaffected.
- Latency from the accept edge: single-cycle ops, done on the next cycle; mul/div, done WIDTH+2 cycles later (34 at WIDTH=32).
- result_hi/result_lo/zero/flags update only when entering DONE. They hold until the next DONE or reset.
- Single-cycle ops. Results go to result_lo; result_hi=0 unless stated. Arithmetic wraps modulo 2^WIDTH and no carry is exported.
  - 00000, 00001, 00010, 00011, 01011: y+b
  - 00100: y−b
  - 00101: shr logical y by b
  - 00110: shl y by b
  - 00111: ror y by b[SHW-1:0]
  - 01000: rol y by b[SHW-1:0]
  - 01001, 01100: y&b
  - 01010, 01101: y|b
  - 10000: −a (two's complement)
  - 10001: ~a
  - 10010: branch_flag ? y+b : y
- Shift width rule: for shl/shr, any set bit of b above SHW-1 gives result 0. Rotates use b modulo WIDTH.
- Mul 01110 (signed × signed): magnitudes are multiplied by shift-add. FIX negates the 2·WIDTH product when the operand signs differ. Result is {result_hi,result_lo}. The most-negative operand is handled exactly, e.g. 0x80000000² = 0x40000000_00000000.
- Div 01111 (signed): restoring division of magnitudes. Quotient truncates toward zero and goes to result_lo. Remainder takes the dividend's sign and goes to result_hi.
- Div boundary cases:
  - b==0: still runs the full latency. result_lo=all ones, result_hi=y, div_by_zero=1.
  - y=most-negative, b=−1: result_lo=y (wraps), result_hi=0, no flag.
- Any other opcode: done after 1 cycle, result=0, zero=1, illegal_op=1.
- div_by_zero and illegal_op clear on the next op that completes without that condition.

Test Plan:
- Reset, then add y=0x7FFFFFFF, b=1 → done 1 cycle after accept; result_lo=0x80000000, hi=0, zero=0. Hold clear=0 → all outputs 0.
- Shifts/rotates: shl y=1,b=31 → 0x80000000; shl b=32 → 0; ror y=0x1,b=33 → 0x80000000; neg a=5 → 0xFFFFFFFB.
- Mul y=−3 (0xFFFFFFFD), b=7 → done exactly 34 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB. A start pulsed mid-op is ignored.
- Div y=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Div y=9, b=0 → lo=0xFFFFFFFF, hi=9, div_by_zero=1.
- Back-to-back: start held through DONE of a mul, then an and → second op accepted in the DONE cycle; its done follows one cycle later.
- clear=0 during DIV iteration 10 → next cycle IDLE, busy=0, no done. opcode 11111 → illegal_op=1, zero=1.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multi-cycle ALU. Single-cycle ops finish with a registered
//            result one cycle after accept. Signed multiply (shift-add) and
//            signed divide (restoring) iterate one bit per cycle, followed by
//            a sign-correction cycle.
// Ports    : clk          - system clock (rising edge)
//            clear        - synchronous active-low reset
//            start        - request, accepted when busy=0 (IDLE or DONE)
//            opcode       - operation select, sampled on accept
//            branch_flag  - condition for the branch-add op
//            a, y, b      - operands (unary source, first, second/shift)
//            busy         - multi-cycle op in flight
//            done         - one-cycle pulse, result valid
//            result_hi/lo - upper/lower result words
//            zero         - {result_hi,result_lo} == 0
//            div_by_zero  - last completed op was a divide by zero
//            illegal_op   - last completed op had an unsupported opcode
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic             branch_flag,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [4:0]     OP_MUL   = 5'b01110;
  localparam logic [4:0]     OP_DIV   = 5'b01111;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;          // quotient/product must be negated
  logic             rem_neg_q, rem_neg_d;  // remainder takes dividend sign
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] y_q, y_d;              // raw dividend for the b==0 case
  logic [WIDTH-1:0] mag_q, mag_d;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;            // partial product hi / remainder
  logic [WIDTH-1:0] lo_q, lo_d;            // multiplier / dividend -> quotient
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  // ---------------------------------------------------------------- single ops
  logic [SHW-1:0]   sh_amt;
  logic [SHW-1:0]   sh_neg;
  logic             sh_big;
  logic [WIDTH-1:0] single_res;
  logic             single_ill;

  always_comb begin
    sh_amt     = b[SHW-1:0];
    // (WIDTH - s) mod WIDTH; a zero rotate then ORs y with itself.
    sh_neg     = SHW'(0) - sh_amt;
    sh_big     = |b[WIDTH-1:SHW];
    single_res = '0;
    single_ill = 1'b0;
    unique case (opcode)
      5'b00000, 5'b00001, 5'b00010,
      5'b00011, 5'b01011: single_res = y + b;
      5'b00100:           single_res = y - b;
      5'b00101:           single_res = sh_big ? '0 : (y >> sh_amt);
      5'b00110:           single_res = sh_big ? '0 : (y << sh_amt);
      5'b00111:           single_res = (y >> sh_amt) | (y << sh_neg);
      5'b01000:           single_res = (y << sh_amt) | (y >> sh_neg);
      5'b01001, 5'b01100: single_res = y & b;
      5'b01010, 5'b01101: single_res = y | b;
      5'b10000:           single_res = '0 - a;
      5'b10001:           single_res = ~a;
      5'b10010:           single_res = branch_flag ? (y + b) : y;
      default:            single_ill = 1'b1;
    endcase
  end

  // -------------------------------------------------------- iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   abs_y;
  logic [WIDTH-1:0]   abs_b;

  always_comb begin
    // Unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1) exactly.
    abs_y     = y[WIDTH-1] ? ('0 - y) : y;
    abs_b     = b[WIDTH-1] ? ('0 - b) : b;
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mag_q : '0)};
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, mag_q};
    prod_fix  = neg_q ? ('0 - {hi_q, lo_q}) : {hi_q, lo_q};
    quo_fix   = neg_q ? ('0 - lo_q) : lo_q;
    rem_fix   = rem_neg_q ? ('0 - hi_q) : hi_q;
  end

  // --------------------------------------------------------- next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_pend_d = dbz_pend_q;
    y_d        = y_q;
    mag_d      = mag_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    zero_d     = zero_q;
    dbz_d      = dbz_q;
    ill_d      = ill_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d = 1'b0;
        if (start) begin
          cnt_d = '0;
          y_d   = y;
          neg_d = y[WIDTH-1] ^ b[WIDTH-1];
          hi_d  = '0;
          if (opcode == OP_MUL) begin
            is_div_d = 1'b0;
            mag_d    = abs_y;
            lo_d     = abs_b;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else if (opcode == OP_DIV) begin
            is_div_d   = 1'b1;
            mag_d      = abs_b;
            lo_d       = abs_y;
            rem_neg_d  = y[WIDTH-1];
            dbz_pend_d = (b == '0);
            busy_d     = 1'b1;
            state_d    = S_DIV;
          end else begin
            done_d   = 1'b1;
            res_hi_d = '0;
            res_lo_d = single_res;
            zero_d   = (single_res == '0);
            dbz_d    = 1'b0;
            ill_d    = single_ill;
            state_d  = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MUL: begin
        // Add-then-shift-right: the multiplier drains out of lo as the
        // product's low word shifts in.
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end

      S_DIV: begin
        // rem_diff[WIDTH] set means the trial subtraction went negative,
        // so the shifted remainder is kept (restored) and the quotient bit is 0.
        if (!rem_diff[WIDTH]) begin
          hi_d = rem_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rem_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end

      S_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ill_d   = 1'b0;
        state_d = S_DONE;
        if (!is_div_q) begin
          res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
          res_lo_d = prod_fix[WIDTH-1:0];
          zero_d   = (prod_fix == '0);
          dbz_d    = 1'b0;
        end else if (dbz_pend_q) begin
          res_hi_d = y_q;
          res_lo_d = '1;
          zero_d   = 1'b0;
          dbz_d    = 1'b1;
        end else begin
          res_hi_d = rem_fix;
          res_lo_d = quo_fix;
          zero_d   = ({rem_fix, quo_fix} == '0);
          dbz_d    = 1'b0;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      y_q        <= '0;
      mag_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      zero_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_pend_q <= dbz_pend_d;
      y_q        <= y_d;
      mag_q      <= mag_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      zero_q     <= zero_d;
      dbz_q      <= dbz_d;
      ill_q      <= ill_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule
`default_nettype wire
